// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, state encoding and pixel packing for the
// receive decoder and the vgaDriver source.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF; // 800
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF; // 525
    localparam int H_START_DEF = H_SYNC_DEF + H_BACK_DEF;                              // 144
    localparam int V_START_DEF = V_SYNC_DEF + V_BACK_DEF;                              // 35

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRAIN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    // RGB444 -> RGB565, replicating the MSBs into the widened low bits
    function automatic logic [15:0] pack565(input logic [3:0] r, input logic [3:0] g,
                                            input logic [3:0] b);
        return {r, r[3], g, g[3:2], b, b[3]};
    endfunction

endpackage

// File: rtl/vga_rx_decoder_if.sv
// Raw VGA link: active-low syncs plus 4-bit colour components.
interface vga_rx_decoder_if;
    logic       h_sync;
    logic       v_sync;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;

    modport master (output h_sync, v_sync, red, green, blue);
    modport slave  (input  h_sync, v_sync, red, green, blue);
endinterface

// File: rtl/vga_sync_edge.sv
// Two-stage sync register with a falling-edge (active-going) pulse taken
// between the first and second stage.
module vga_sync_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sync_i,
    output logic fall_o
);
    logic s1_q, s2_q;

    // Reset to the inactive level so a released reset never fakes an edge
    // unless the source is actually low.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= sync_i;
            s2_q <= s1_q;
        end
    end

    assign fall_o = s2_q & ~s1_q;
endmodule

// File: rtl/vga_rx_decoder.sv
// VGA receiver: recovers line/frame position from the syncs, locks after two
// clean frames and emits RGB565 pixels with coordinates, two clocks after the pins.
module vga_rx_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        hSync_i,
    input  logic        vSync_i,
    input  logic [3:0]  red_i,
    input  logic [3:0]  green_i,
    input  logic [3:0]  blue_i,
    output logic [15:0] rgb_o,
    output logic        pixel_valid_o,
    output logic [9:0]  column_o,
    output logic [9:0]  row_o,
    output logic        frame_start_o,
    output logic        locked_o,
    output logic        sync_err_o,
    output logic [7:0]  err_count_o
);
    localparam cnt_t H_LAST  = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam cnt_t H_FIRST = cnt_t'(H_SYNC + H_BACK);
    localparam cnt_t H_END   = cnt_t'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam cnt_t V_FIRST = cnt_t'(V_SYNC + V_BACK);
    localparam cnt_t V_END   = cnt_t'(V_SYNC + V_BACK + V_VISIBLE - 1);

    logic       h_fall, v_fall;
    logic [3:0] r_s1, g_s1, b_s1;

    vga_sync_edge u_hsync (.clk_i(clk_i), .reset_i(reset_i), .sync_i(hSync_i), .fall_o(h_fall));
    vga_sync_edge u_vsync (.clk_i(clk_i), .reset_i(reset_i), .sync_i(vSync_i), .fall_o(v_fall));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_s1 <= '0;
            g_s1 <= '0;
            b_s1 <= '0;
        end else begin
            r_s1 <= red_i;
            g_s1 <= green_i;
            b_s1 <= blue_i;
        end
    end

    // h_cur/v_cur are the position of the sample currently sitting in S1;
    // the registered copies hold the previous sample's position.
    cnt_t hcnt_q, vcnt_q, h_cur, v_cur;
    logic line_err, frame_err, viol;

    always_comb begin
        h_cur     = hcnt_q;
        v_cur     = vcnt_q;
        line_err  = 1'b0;
        frame_err = 1'b0;
        if (h_fall) begin
            h_cur    = '0;
            line_err = (hcnt_q != H_LAST);
        end else if (hcnt_q != CNT_MAX) begin
            h_cur    = hcnt_q + 1'b1;
            line_err = (h_cur == CNT_MAX);
        end
        if (v_fall) begin
            v_cur     = '0;
            frame_err = (vcnt_q != V_LAST);
        end else if (h_fall && vcnt_q != CNT_MAX) begin
            v_cur     = vcnt_q + 1'b1;
            frame_err = (v_cur == CNT_MAX);
        end
    end

    assign viol = line_err | frame_err;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= h_cur;
            vcnt_q <= v_cur;
        end
    end

    rx_state_e  state_q, state_d;
    logic [1:0] good_q, good_d;
    logic       err_pulse;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Any violation in TRAIN restarts the search, so reaching a vSync edge
    // while still in TRAIN means the frame just ended clean.
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        err_pulse = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (v_fall) begin
                    state_d = TRAIN;
                    good_d  = '0;
                end
            end
            TRAIN: begin
                if (viol) begin
                    state_d = SEARCH;
                end else if (v_fall) begin
                    good_d = good_q + 1'b1;
                    if (good_q == 2'd1) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (viol) begin
                    state_d   = SEARCH;
                    err_pulse = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign locked_o = (state_q == LOCKED);

    logic pix_ok;
    assign pix_ok = locked_o && (h_cur >= H_FIRST) && (h_cur <= H_END)
                             && (v_cur >= V_FIRST) && (v_cur <= V_END);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rgb_o         <= '0;
            pixel_valid_o <= 1'b0;
            column_o      <= '0;
            row_o         <= '0;
            frame_start_o <= 1'b0;
            sync_err_o    <= 1'b0;
            err_count_o   <= '0;
        end else begin
            pixel_valid_o <= pix_ok;
            frame_start_o <= pix_ok && (h_cur == H_FIRST) && (v_cur == V_FIRST);
            rgb_o         <= pix_ok ? pack565(r_s1, g_s1, b_s1) : '0;
            column_o      <= pix_ok ? h_cur - H_FIRST : '0;
            row_o         <= pix_ok ? v_cur - V_FIRST : '0;
            sync_err_o    <= err_pulse;
            if (err_pulse && err_count_o != 8'hFF) err_count_o <= err_count_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_rx_decoder.sv
// Drives a behavioural VGA source (shrunk timing) into vga_rx_decoder and
// checks every output cycle against a frame-level reference model.
module tb_vga_rx_decoder;
    localparam int HV = 6, HF = 1, HS = 2, HB = 1;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1;
    localparam int H_TOTAL = HV + HF + HS + HB;   // 10
    localparam int V_TOTAL = VV + VF + VS + VB;   // 6
    localparam int H_FIRST = HS + HB;
    localparam int V_FIRST = VS + VB;

    logic        clk_i, reset_i;
    logic [15:0] rgb_o;
    logic        pixel_valid_o, frame_start_o, locked_o, sync_err_o;
    logic [9:0]  column_o, row_o;
    logic [7:0]  err_count_o;

    vga_rx_decoder_if vga ();

    vga_rx_decoder #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .hSync_i(vga.h_sync), .vSync_i(vga.v_sync),
        .red_i(vga.red), .green_i(vga.green), .blue_i(vga.blue),
        .rgb_o(rgb_o), .pixel_valid_o(pixel_valid_o),
        .column_o(column_o), .row_o(row_o),
        .frame_start_o(frame_start_o), .locked_o(locked_o),
        .sync_err_o(sync_err_o), .err_count_o(err_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0, n_fail = 0, serr_seen = 0;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] dut_word();
        return {pixel_valid_o, frame_start_o, rgb_o, row_o, column_o,
                locked_o, sync_err_o, err_count_o};
    endfunction

    typedef struct packed {
        logic        probe;
        logic [47:0] w;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: line/frame lengths since the last sync edges and
    // the lock progress, kept as plain integers.
    bit m_prev_h, m_prev_v, m_locked, m_train;
    int m_lage, m_lines, m_good, m_err;

    task automatic model_reset();
        m_prev_h = 1; m_prev_v = 1;
        m_lage = 0; m_lines = 0;
        m_locked = 0; m_train = 0; m_good = 0; m_err = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic h, input logic v, input logic [3:0] r,
                              input logic [3:0] g, input logic [3:0] b,
                              input int px, input int py, input bit probe);
        bit ls, fs, viol, vis, valid, fso, serr;
        int rgb_i;
        logic [15:0] rgb;
        logic [9:0]  row, col;
        exp_t e;
        ls = !h && m_prev_h;
        fs = !v && m_prev_v;
        m_prev_h = h; m_prev_v = v;
        viol = 0;
        if (ls) begin
            if (m_lage != H_TOTAL - 1) viol = 1;
            m_lage = 0;
        end else if (m_lage < 1023) begin
            m_lage++;
            if (m_lage == 1023) viol = 1;
        end
        if (fs) begin
            if (m_lines != V_TOTAL - 1) viol = 1;
            m_lines = 0;
        end else if (ls && m_lines < 1023) begin
            m_lines++;
            if (m_lines == 1023) viol = 1;
        end
        vis   = px >= H_FIRST && px < H_FIRST + HV && py >= V_FIRST && py < V_FIRST + VV;
        valid = m_locked && vis;
        rgb_i = ((int'(r) * 2 + int'(r) / 8) << 11) | ((int'(g) * 4 + int'(g) / 4) << 5)
              | (int'(b) * 2 + int'(b) / 8);
        rgb   = valid ? 16'(rgb_i) : 16'h0;
        row   = valid ? 10'(py - V_FIRST) : 10'd0;
        col   = valid ? 10'(px - H_FIRST) : 10'd0;
        fso   = valid && py == V_FIRST && px == H_FIRST;
        serr  = 0;
        if (m_locked) begin
            if (viol) begin
                serr = 1; m_locked = 0;
                if (m_err < 255) m_err++;
            end
        end else if (m_train) begin
            if (viol) m_train = 0;
            else if (fs) begin
                m_good++;
                if (m_good == 2) begin m_train = 0; m_locked = 1; end
            end
        end else if (fs) begin
            m_train = 1; m_good = 0;
        end
        e.probe = probe;
        e.w = {valid, fso, rgb, row, col, m_locked, serr, 8'(m_err)};
        exp_q.push_back(e);
    endtask

    // Called at a falling edge: outputs now reflect the sample from two ticks ago.
    task automatic tick(input logic h, input logic v, input logic [3:0] r, input logic [3:0] g,
                        input logic [3:0] b, input int px, input int py, input bit probe);
        exp_t e;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            chk("cycle", dut_word(), e.w);
            if (e.probe) begin
                chk("px00_rgb", 48'(rgb_o), 48'hFFFF);
                chk("px00_valid", 48'(pixel_valid_o), 48'd1);
                chk("px00_fs", 48'(frame_start_o), 48'd1);
            end
        end
        serr_seen += int'(sync_err_o);
        vga.h_sync = h; vga.v_sync = v;
        vga.red = r; vga.green = g; vga.blue = b;
        model_step(h, v, r, g, b, px, py, probe);
        @(negedge clk_i);
    endtask

    task automatic drive_lines(input int y0, input int y1, input int short_y, input bit pin00);
        logic [3:0] r, g, b;
        bit vis, probe;
        for (int y = y0; y <= y1; y++) begin
            for (int p = 0; p < ((y == short_y) ? H_TOTAL - 1 : H_TOTAL); p++) begin
                vis   = p >= H_FIRST && p < H_FIRST + HV && y >= V_FIRST && y < V_FIRST + VV;
                probe = pin00 && p == H_FIRST && y == V_FIRST;
                r = vis ? 4'($urandom) : 4'h0;
                g = vis ? 4'($urandom) : 4'h0;
                b = vis ? 4'($urandom) : 4'h0;
                if (probe) begin r = 4'hF; g = 4'hF; b = 4'hF; end
                tick(!(p < HS), !(y < VS), r, g, b, p, y, probe);
            end
        end
    endtask

    task automatic drive_frame(input int short_y, input bit pin00);
        drive_lines(0, V_TOTAL - 1, short_y, pin00);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        #1;
        chk("rst_out", dut_word(), 48'h0);
        @(negedge clk_i);
        reset_i = 1'b0;
        model_reset();
    endtask

    int s0;

    initial begin
        reset_i = 1'b1;
        vga.h_sync = 1'b1; vga.v_sync = 1'b1;
        vga.red = '0; vga.green = '0; vga.blue = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_init", dut_word(), 48'h0);
        reset_i = 1'b0;

        // lock after two clean frames, pixel (0,0) of frame 3
        drive_frame(-1, 0);
        drive_frame(-1, 0);
        chk("f2_unlocked", 48'(locked_o), 48'd0);
        drive_frame(-1, 1);
        chk("f3_locked", 48'(locked_o), 48'd1);
        chk("f3_errcnt", 48'(err_count_o), 48'd0);

        // one line one clock short
        s0 = serr_seen;
        drive_frame(1, 0);
        chk("short_pulses", 48'(serr_seen - s0), 48'd1);
        chk("short_unlocked", 48'(locked_o), 48'd0);
        chk("short_errcnt", 48'(err_count_o), 48'd1);
        drive_frame(-1, 0);
        drive_frame(-1, 0);
        chk("short_train", 48'(locked_o), 48'd0);
        drive_frame(-1, 0);
        chk("short_relock", 48'(locked_o), 48'd1);

        // hSync stuck high long enough to saturate the line counter
        s0 = serr_seen;
        for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, -1, -1, 1'b0);
        chk("hold_pulses", 48'(serr_seen - s0), 48'd1);
        chk("hold_unlocked", 48'(locked_o), 48'd0);
        chk("hold_errcnt", 48'(err_count_o), 48'd2);
        repeat (3) drive_frame(-1, 0);
        chk("hold_relock", 48'(locked_o), 48'd1);

        // reset in the middle of a frame
        drive_lines(0, 2, -1, 0);
        do_reset();
        drive_lines(3, V_TOTAL - 1, -1, 0);
        drive_frame(-1, 0);
        drive_frame(-1, 0);
        chk("rstm_train", 48'(locked_o), 48'd0);
        drive_frame(-1, 0);
        chk("rstm_relock", 48'(locked_o), 48'd1);

        // error counter saturation
        s0 = serr_seen;
        for (int k = 0; k < 300; k++) begin
            drive_frame(1, 0);
            drive_frame(-1, 0);
            drive_frame(-1, 0);
        end
        chk("sat_pulses", 48'(serr_seen - s0), 48'd300);
        chk("sat_errcnt", 48'(err_count_o), 48'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
